data_mem_responder: RTL and testbench

//   Responder (slave) end of the processor's data-memory port. Accepts one

---
 rtl/data_mem_responder.sv | 178 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Brief    : Data-memory responder with RV32I byte/half/word lane handling,
//             misalignment/illegal-funct3 detection and programmable latency.
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_BITS = 9,
  parameter int WAIT_STATES   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         c_DEPTH     = 1 << RAM_ADDR_BITS;
  localparam logic [3:0] c_WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [RAM_WIDTH-1:0]     r_mem [c_DEPTH];
  logic [3:0]               r_wait_cnt;
  logic [31:0]              r_pend_rdata;
  logic                     r_pend_err;
  logic [31:0]              r_rsp_rdata;
  logic                     r_rsp_err;

  logic                     w_accept;
  logic                     w_wait_done;
  logic                     w_enter_resp;
  logic [RAM_ADDR_BITS-1:0] w_idx;
  logic [1:0]               w_off;
  logic                     w_is_half;
  logic                     w_is_word;
  logic                     w_f3_ok;
  logic                     w_misaligned;
  logic                     w_err;
  logic [31:0]              w_word;
  logic [7:0]               w_byte;
  logic [15:0]              w_half;
  logic [31:0]              w_load_result;
  logic [3:0]               w_be;
  logic [31:0]              w_store_data;
  logic                     w_unused_addr;

  // Upper address bits alias onto the RAM.
  assign w_idx         = req_addr[RAM_ADDR_BITS+1:2];
  assign w_off         = req_addr[1:0];
  assign w_unused_addr = ^req_addr[31:RAM_ADDR_BITS+2];

  assign w_is_half    = (req_funct3[1:0] == 2'b01);
  assign w_is_word    = (req_funct3[1:0] == 2'b10);
  assign w_f3_ok      = req_we ? (req_funct3 <= 3'd2)
                               : ((req_funct3 != 3'd3) && (req_funct3 != 3'd6) &&
                                  (req_funct3 != 3'd7));
  assign w_misaligned = (w_is_half & w_off[0]) | (w_is_word & (w_off != 2'b00));
  assign w_err        = ~w_f3_ok | w_misaligned;

  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{w_off, 3'b000} +: 8];
  assign w_half = w_off[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_load_result = 32'd0;
    if (!req_we && !w_err) begin
      case (req_funct3)
        3'd0:    w_load_result = {{24{w_byte[7]}}, w_byte};
        3'd1:    w_load_result = {{16{w_half[15]}}, w_half};
        3'd2:    w_load_result = w_word;
        3'd4:    w_load_result = {24'd0, w_byte};
        3'd5:    w_load_result = {16'd0, w_half};
        default: w_load_result = 32'd0;
      endcase
    end
  end

  // Store data is replicated across lanes; the byte-enables pick the target.
  always_comb begin
    w_be         = 4'b0000;
    w_store_data = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        w_be         = 4'b0001 << w_off;
        w_store_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be         = w_off[1] ? 4'b1100 : 4'b0011;
        w_store_data = {2{req_wdata[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept && req_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_store_data[8*i +: 8];
      end
    end
  end

  assign w_wait_done = (r_wait_cnt == c_WAIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        w_accept  = req_valid & ~reset;
        if (w_accept) w_next_state = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        if (w_wait_done) w_next_state = S_RESP;
      end
      S_RESP: begin
        rsp_valid    = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_enter_resp = (w_next_state == S_RESP) && (r_state != S_RESP);

  // Outputs only change on entry to RESP so they hold between responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt   <= 4'd0;
      r_pend_rdata <= 32'd0;
      r_pend_err   <= 1'b0;
      r_rsp_rdata  <= 32'd0;
      r_rsp_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wait_cnt   <= 4'd0;
        r_pend_rdata <= w_load_result;
        r_pend_err   <= w_err;
      end else if (r_state == S_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end
      if (w_enter_resp) begin
        r_rsp_rdata <= (r_state == S_IDLE) ? w_load_result : r_pend_rdata;
        r_rsp_err   <= (r_state == S_IDLE) ? w_err : r_pend_err;
      end
    end
  end

  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_responder
//  Brief    : Bench for data_mem_responder; two instances (0 and 3 wait
//             states) checked against a byte-addressed reference memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [2:0]  req_funct3[2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  logic [7:0]  ref_bytes [2][2048];
  logic [31:0] prev_rd   [2];
  logic        prev_err  [2];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.RAM_WIDTH(32), .RAM_ADDR_BITS(9), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  data_mem_responder #(.RAM_WIDTH(32), .RAM_ADDR_BITS(9), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: 2 KiB little-endian byte memory, address taken modulo its size.
  function automatic void model(input int d, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] rd, output logic err);
    int  size;
    int  a;
    bit  legal;
    logic [31:0] v;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f3[1:0];
    a     = int'(addr % 2048);
    rd    = 32'd0;
    err   = !legal || ((a % size) != 0);
    if (err) return;
    if (we) begin
      for (int i = 0; i < size; i++) ref_bytes[d][a+i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v = v | (32'(ref_bytes[d][a+i]) << (8*i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
      rd = v;
    end
  endfunction

  task automatic do_req(input int d, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] got_rd, output logic got_err);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          lat;
    int          busy;
    int          hold_bad;
    req_valid[d] = 1'b1; req_we[d] = we; req_funct3[d] = f3;
    req_addr[d]  = addr; req_wdata[d] = wd;
    lat = 0;
    while (!req_ready[d] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq($sformatf("d%0d_ready_wait", d), 32'(lat < 20), 32'd1);
    model(d, we, f3, addr, wd, exp_rd, exp_err);
    @(posedge clk);
    #1;
    // Scrambled inputs after accept must be ignored.
    req_valid[d] = 1'b0; req_we[d] = 1'($urandom); req_funct3[d] = 3'($urandom);
    req_addr[d]  = $urandom; req_wdata[d] = $urandom;
    lat = 0; busy = 0; hold_bad = 0;
    do begin
      @(negedge clk);
      lat++;
      if (req_ready[d]) busy++;
      if (!rsp_valid[d] && (rsp_rdata[d] !== prev_rd[d] || rsp_err[d] !== prev_err[d]))
        hold_bad++;
    end while (!rsp_valid[d] && lat < 20);
    check_eq($sformatf("d%0d_latency", d), lat, wait_of(d) + 1);
    check_eq($sformatf("d%0d_ready_busy", d), busy, 0);
    check_eq($sformatf("d%0d_hold_wait", d), hold_bad, 0);
    check_eq($sformatf("d%0d_rdata a=%h f3=%0d we=%0d", d, addr, f3, we), rsp_rdata[d], exp_rd);
    check_eq($sformatf("d%0d_err a=%h f3=%0d we=%0d", d, addr, f3, we), 32'(rsp_err[d]), 32'(exp_err));
    got_rd  = rsp_rdata[d];
    got_err = rsp_err[d];
    @(negedge clk);
    check_eq($sformatf("d%0d_one_cycle", d), 32'(rsp_valid[d]), 32'd0);
    check_eq($sformatf("d%0d_ready_back", d), 32'(req_ready[d]), 32'd1);
    check_eq($sformatf("d%0d_hold_after", d), rsp_rdata[d], exp_rd);
    prev_rd[d]  = exp_rd;
    prev_err[d] = exp_err;
  endtask

  // req_valid held high: response pulses must repeat every WAIT_STATES+2 cycles.
  task automatic burst(input int d, input logic [31:0] addr);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          wt;
    int          mask_got;
    int          mask_exp;
    wt = wait_of(d);
    model(d, 1'b0, 3'd2, addr, 32'd0, exp_rd, exp_err);
    req_valid[d] = 1'b1; req_we[d] = 1'b0; req_funct3[d] = 3'd2; req_addr[d] = addr;
    mask_got = 0; mask_exp = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (rsp_valid[d]) begin
        mask_got = mask_got | (1 << c);
        check_eq($sformatf("d%0d_burst_rdata", d), rsp_rdata[d], exp_rd);
      end
      if ((c % (wt + 2)) == wt + 1) mask_exp = mask_exp | (1 << c);
    end
    req_valid[d] = 1'b0;
    check_eq($sformatf("d%0d_burst_pulses", d), mask_got, mask_exp);
    prev_rd[d]  = exp_rd;
    prev_err[d] = exp_err;
  endtask

  logic [31:0] rd;
  logic        er;
  logic [31:0] ra;
  logic [2:0]  rf;
  logic        rw;

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_funct3[d] = 3'd0;
      req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
      prev_rd[d] = 32'd0; prev_err[d] = 1'b0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("d%0d_rst_ready", d), 32'(req_ready[d]), 32'd1);
      check_eq($sformatf("d%0d_rst_valid", d), 32'(rsp_valid[d]), 32'd0);
      check_eq($sformatf("d%0d_rst_rdata", d), rsp_rdata[d], 32'd0);
      check_eq($sformatf("d%0d_rst_err", d), 32'(rsp_err[d]), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Fill both RAMs so every later load has a known reference.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 512; i++)
        do_req(d, 1'b1, 3'd2, ($urandom & ~32'h7FF) | 32'(i << 2), $urandom, rd, er);

    do_req(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, er);
    do_req(0, 1'b0, 3'd2, 32'h10, 32'h0, rd, er);
    check_eq("t1_lw", rd, 32'hDEADBEEF);
    check_eq("t1_err", 32'(er), 32'd0);
    do_req(0, 1'b1, 3'd0, 32'h13, 32'h80, rd, er);
    do_req(0, 1'b0, 3'd0, 32'h13, 32'h0, rd, er);
    check_eq("t2_lb", rd, 32'hFFFFFF80);
    do_req(0, 1'b0, 3'd4, 32'h13, 32'h0, rd, er);
    check_eq("t2_lbu", rd, 32'h00000080);
    do_req(0, 1'b0, 3'd2, 32'h10, 32'h0, rd, er);
    check_eq("t2_lw", rd, 32'h80ADBEEF);
    do_req(0, 1'b1, 3'd1, 32'h10, 32'h1234, rd, er);
    do_req(0, 1'b0, 3'd2, 32'h10, 32'h0, rd, er);
    check_eq("t3_lw", rd, 32'h80AD1234);
    do_req(0, 1'b0, 3'd5, 32'h12, 32'h0, rd, er);
    check_eq("t3_lhu", rd, 32'h000080AD);
    do_req(0, 1'b0, 3'd1, 32'h11, 32'h0, rd, er);
    check_eq("t3_lh_mis_err", 32'(er), 32'd1);
    check_eq("t3_lh_mis_rdata", rd, 32'd0);
    do_req(0, 1'b1, 3'd2, 32'h21, 32'hFFFFFFFF, rd, er);
    check_eq("t4_sw_mis_err", 32'(er), 32'd1);
    do_req(0, 1'b0, 3'd2, 32'h20, 32'h0, rd, er);
    do_req(0, 1'b0, 3'd3, 32'h20, 32'h0, rd, er);
    check_eq("t4_f3_err", 32'(er), 32'd1);
    do_req(0, 1'b1, 3'd2, 32'h800, 32'hA5A5A5A5, rd, er);
    do_req(0, 1'b0, 3'd2, 32'h000, 32'h0, rd, er);
    check_eq("t6_alias", rd, 32'hA5A5A5A5);

    burst(0, 32'h10);
    burst(1, 32'h44);

    // Reset in WAIT drops the response but keeps the committed store.
    model(1, 1'b1, 3'd2, 32'h100, 32'hCAFEF00D, rd, er);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_funct3[1] = 3'd2;
    req_addr[1] = 32'h100; req_wdata[1] = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("rst_mid_ready", 32'(req_ready[1]), 32'd1);
    check_eq("rst_mid_rdata", rsp_rdata[1], 32'd0);
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (rsp_valid[1]) seen++;
      end
      check_eq("rst_mid_no_rsp", seen, 0);
    end
    for (int d = 0; d < 2; d++) begin
      prev_rd[d] = 32'd0; prev_err[d] = 1'b0;
    end
    do_req(1, 1'b0, 3'd2, 32'h100, 32'h0, rd, er);
    check_eq("rst_mid_store_kept", rd, 32'hCAFEF00D);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < ((d == 0) ? 300 : 100); i++) begin
        rw = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0) rf = 3'($urandom);
        else if (rw)                   rf = 3'($urandom_range(0, 2));
        else begin
          rf = 3'($urandom_range(0, 4));
          if (rf == 3'd3) rf = 3'd5;
        end
        ra = $urandom;
        if ($urandom_range(0, 1) == 0) ra[1:0] = 2'b00;
        do_req(d, rw, rf, ra, $urandom, rd, er);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
